iter_shift_unit: RTL and testbench

Multi-cycle iterative shifter implementing RV32I SLL/SRL/SRA (register and immediate forms) for area-constrained integer ALU configurations. It accepts the same operand and funct encoding the integer ALU decode already produces and returns the result over a valid/ready handshake. It replaces the single-cycle barrel shifter when the core is built for minimum area. It also serves as the template for other multi-cycle execute units.

---
 rtl/alu_pkg.sv | 17 +
 rtl/shift_step.sv | 30 +++
 rtl/iter_shift_unit.sv | 107 ++++++++++
 tb/tb_iter_shift_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the integer ALU execute units: shift op encodings and
// the iterative shifter's state type.
package alu_pkg;

    // {funct7_5, funct3_2}
    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_ILL = 2'b10;
    localparam logic [1:0] SH_SRA = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by 1 or by STEP positions,
// left with zero fill or right with a caller-supplied fill bit.
module shift_step #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned STEP = 4
) (
    input  logic [XLEN-1:0] data,
    input  logic            dir,
    input  logic            fill,
    input  logic            big,
    output logic [XLEN-1:0] shifted
);

    logic [XLEN-1:0] fill_mask;
    logic [XLEN-1:0] right;

    // Ones in the vacated upper bits of a right shift.
    assign fill_mask = big ? ~({XLEN{1'b1}} >> STEP) : ~({XLEN{1'b1}} >> 1);
    assign right     = big ? (data >> STEP) : (data >> 1);

    always_comb begin
        shifted = '0;
        if (dir) begin
            shifted = right | (fill ? fill_mask : '0);
        end else begin
            shifted = big ? (data << STEP) : (data << 1);
        end
    end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle RV32I shifter (SLL/SRL/SRA) with valid/ready handshakes; moves
// STEP bits per cycle while enough shift remains, then single bits.
module iter_shift_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned STEP = 4
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] Rs1,
    input  logic [4:0]      Rs2,
    input  logic            funct3_2,
    input  logic            funct7_5,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result
);

    localparam logic [4:0] StepAmt = 5'(STEP);

    shift_state_e    state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [XLEN-1:0] step_out;
    logic            fill_q, fill_d;
    logic            dir_q, dir_d;
    logic            big;
    logic            illegal;
    logic [1:0]      op;

    assign op      = {funct7_5, funct3_2};
    assign illegal = (op == SH_ILL);
    assign big     = (cnt_q >= StepAmt);

    shift_step #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_step (
        .data    (data_q),
        .dir     (dir_q),
        .fill    (fill_q),
        .big     (big),
        .shifted (step_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        fill_d  = fill_q;
        dir_d   = dir_q;
        // Flush wins over everything and leaves the data register untouched.
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        data_d  = illegal ? '0 : Rs1;
                        cnt_d   = illegal ? 5'd0 : Rs2;
                        dir_d   = funct3_2;
                        fill_d  = (op == SH_SRA) && Rs1[XLEN-1];
                        state_d = (illegal || (Rs2 == 5'd0)) ? StDone : StShift;
                    end
                end
                StShift: begin
                    data_d = step_out;
                    cnt_d  = cnt_q - (big ? StepAmt : 5'd1);
                    if (cnt_q == (big ? StepAmt : 5'd1)) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            fill_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
            dir_q   <= dir_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign Result    = data_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit: directed corner cases plus random
// traffic checked every cycle against a latency/result model.
module tb_iter_shift_unit;

    localparam int unsigned STEP = 4;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] Rs1 = '0;
    logic [4:0]  Rs2 = '0;
    logic        funct3_2 = 1'b0;
    logic        funct7_5 = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] Result;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    iter_shift_unit #(
        .XLEN (32),
        .STEP (STEP)
    ) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Rs1       (Rs1),
        .Rs2       (Rs2),
        .funct3_2  (funct3_2),
        .funct7_5  (funct7_5),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s,
                                              input logic f7, input logic f3);
        case ({f7, f3})
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b11:   return $signed(a) >>> s;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_steps(input logic [4:0] s, input logic f7, input logic f3);
        if ({f7, f3} == 2'b10) return 0;
        return int'(s) / STEP + int'(s) % STEP;
    endfunction

    // Reference: idle, waiting m_wait more cycles, or holding a result.
    logic        m_busy;
    logic        m_valid;
    logic [31:0] m_result;
    int          m_wait;

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_valid  <= 1'b0;
            m_result <= '0;
            m_wait   <= 0;
        end else if (flush) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy   <= 1'b1;
                m_result <= ref_shift(Rs1, Rs2, funct7_5, funct3_2);
                m_wait   <= ref_steps(Rs2, funct7_5, funct3_2);
                m_valid  <= (ref_steps(Rs2, funct7_5, funct3_2) == 0);
            end
        end else if (!m_valid) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) m_valid <= 1'b1;
        end else if (out_ready) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end
    end

    always @(negedge CLK) begin
        check32("cyc_in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
        check32("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        if (m_valid) check32("cyc_result", Result, m_result);
    end

    task automatic start_op(input logic [31:0] a, input logic [4:0] s,
                            input logic f7, input logic f3);
        Rs1 = a; Rs2 = s; funct7_5 = f7; funct3_2 = f3; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        // Operands must be ignored after acceptance.
        Rs1 = $urandom; Rs2 = 5'($urandom); funct7_5 = 1'($urandom); funct3_2 = 1'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic do_op(input string name, input logic [31:0] a, input logic [4:0] s,
                         input logic f7, input logic f3, input logic [31:0] exp_res,
                         input int exp_lat);
        int lat;
        start_op(a, s, f7, f3);
        wait_valid(lat);
        check32({name, "_latency"}, lat, exp_lat);
        check32({name, "_result"}, Result, exp_res);
        @(posedge CLK); #1;
    endtask

    initial begin
        int  lat;
        logic seen;
        logic [31:0] held;

        #1 rst_n = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        check32("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check32("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check32("reset_result", Result, 32'h0);
        rst_n = 1'b1;
        @(posedge CLK); #1;

        check32("model_sll", ref_shift(32'h1, 5'd31, 1'b0, 1'b0), 32'h8000_0000);
        check32("model_sra", ref_shift(32'h8000_00F0, 5'd5, 1'b1, 1'b1), 32'hFC00_0007);
        check32("model_srl", ref_shift(32'h8000_00F0, 5'd5, 1'b0, 1'b1), 32'h0400_0007);
        check32("model_steps", ref_steps(5'd31, 1'b0, 1'b0), 32'd10);

        do_op("sll31", 32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000, 11);
        do_op("sra5", 32'h8000_00F0, 5'd5, 1'b1, 1'b1, 32'hFC00_0007, 3);
        do_op("srl5", 32'h8000_00F0, 5'd5, 1'b0, 1'b1, 32'h0400_0007, 3);
        do_op("zero", 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1);
        do_op("illegal", 32'h1234_5678, 5'd7, 1'b1, 1'b0, 32'h0000_0000, 1);
        do_op("sra4", 32'hF000_0000, 5'd4, 1'b1, 1'b1, 32'hFF00_0000, 2);

        // Backpressure.
        out_ready = 1'b0;
        start_op(32'h8000_00F0, 5'd5, 1'b0, 1'b1);
        wait_valid(lat);
        check32("bp_latency", lat, 32'd3);
        held = Result;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            check32("bp_valid", {31'b0, out_valid}, 32'd1);
            check32("bp_result", Result, held);
            check32("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge CLK); #1;
        check32("bp_release", {31'b0, in_ready}, 32'd1);

        // Flush during SHIFT.
        start_op(32'h0000_0001, 5'd31, 1'b0, 1'b0);
        repeat (3) begin @(posedge CLK); #1; end
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        check32("flush_in_ready", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            seen |= out_valid;
            @(posedge CLK); #1;
        end
        check32("flush_no_valid", {31'b0, seen}, 32'd0);
        do_op("after_flush", 32'h0000_00FF, 5'd9, 1'b0, 1'b0, 32'h0001_FE00, 4);

        // Asynchronous reset mid-operation.
        start_op(32'h0000_0001, 5'd31, 1'b0, 1'b0);
        @(posedge CLK); #3;
        rst_n = 1'b0;
        #1;
        check32("arst_in_ready", {31'b0, in_ready}, 32'd1);
        check32("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check32("arst_result", Result, 32'h0);
        @(posedge CLK); #1;
        rst_n = 1'b1;
        @(posedge CLK); #1;

        // Random traffic checked by the per-cycle compare.
        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            Rs1       = $urandom;
            case ($urandom_range(0, 5))
                0:       Rs2 = 5'd0;
                1:       Rs2 = 5'd31;
                default: Rs2 = 5'($urandom);
            endcase
            funct7_5 = 1'($urandom);
            funct3_2 = 1'($urandom);
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (20) begin @(posedge CLK); #1; end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
